// File: rtl/clkgen_pkg.sv
// clkgen_pkg: shared FSM state type and ratio validity check for clkgen_frac.
package clkgen_pkg;
    typedef enum logic {SETTLE, LOCKED} state_t;
    function automatic logic ratio_ok(input logic [31:0] num, input logic [31:0] den);
        return (den != 32'd0) && (num <= den);
    endfunction
endpackage

// File: rtl/clkgen_frac_chan.sv
// clkgen_frac_chan: one fractional phase-accumulator channel producing a NUM/DEN enable strobe.
module clkgen_frac_chan #(
    parameter int ACC_W = 16,
    parameter logic [ACC_W-1:0] INIT_NUM = ACC_W'(1),
    parameter logic [ACC_W-1:0] INIT_DEN = ACC_W'(4)
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             clear,
    input  logic             load,
    input  logic [ACC_W-1:0] num,
    input  logic [ACC_W-1:0] den,
    output logic             ce
);
    import clkgen_pkg::*;
    logic [ACC_W-1:0] num_q, den_q, acc;
    logic [ACC_W:0]   sum;
    logic             hit;
    assign sum = {1'b0, acc} + {1'b0, num_q};
    assign hit = sum >= {1'b0, den_q};
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            num_q <= INIT_NUM;
            den_q <= INIT_DEN;
            acc   <= '0;
            ce    <= 1'b0;
        end else begin
            if (load) begin
                num_q <= num;
                den_q <= den;
            end
            if (clear || !run) begin
                acc <= '0;
                ce  <= 1'b0;
            end else begin
                acc <= hit ? ACC_W'(sum - {1'b0, den_q}) : sum[ACC_W-1:0];
                ce  <= hit;
            end
        end
    end
endmodule

// File: rtl/clkgen_frac.sv
// clkgen_frac: multi-channel fractional clock-enable generator with settle/lock FSM
// and a runtime ratio reconfiguration port.
module clkgen_frac #(
    parameter int CHANNELS = 3,
    parameter int ACC_W = 16,
    parameter int LOCK_CYCLES = 1024,
    parameter logic [CHANNELS*ACC_W-1:0] INIT_NUM = {CHANNELS{ACC_W'(1)}},
    parameter logic [CHANNELS*ACC_W-1:0] INIT_DEN = {CHANNELS{ACC_W'(4)}},
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                refclk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_chan,
    input  logic [ACC_W-1:0]    cfg_num,
    input  logic [ACC_W-1:0]    cfg_den,
    output logic                cfg_err,
    output logic [CHANNELS-1:0] ce_out,
    output logic                locked
);
    import clkgen_pkg::*;
    localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    state_t           state;
    logic [CNT_W-1:0] count;
    logic             accept, good, take;
    assign accept = cfg_valid && cfg_ready;
    assign good   = (int'(cfg_chan) < CHANNELS) && ratio_ok(32'(cfg_num), 32'(cfg_den));
    assign take   = accept && good;
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SETTLE;
            count     <= '0;
            locked    <= 1'b0;
            cfg_ready <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= accept && !good;
            if (state == SETTLE) begin
                if (count == CNT_W'(LOCK_CYCLES - 1)) begin
                    state     <= LOCKED;
                    locked    <= 1'b1;
                    cfg_ready <= 1'b1;
                    count     <= '0;
                end else begin
                    count <= count + 1'b1;
                end
            end else if (take) begin
                state     <= SETTLE;
                locked    <= 1'b0;
                cfg_ready <= 1'b0;
            end
        end
    end
    // A valid reconfig clears every accumulator so all channels relock phase-aligned.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        clkgen_frac_chan #(
            .ACC_W(ACC_W),
            .INIT_NUM(INIT_NUM[c*ACC_W +: ACC_W]),
            .INIT_DEN(INIT_DEN[c*ACC_W +: ACC_W])
        ) u_chan (
            .refclk(refclk),
            .rst_n(rst_n),
            .run(state == LOCKED),
            .clear(take),
            .load(take && cfg_chan == CH_W'(c)),
            .num(cfg_num),
            .den(cfg_den),
            .ce(ce_out[c])
        );
    end
endmodule

// File: tb/tb_clkgen_frac.sv
// tb_clkgen_frac: directed self-checking bench for clkgen_frac (3 channels, 16-cycle lock).
module tb_clkgen_frac;
    localparam int LOCK = 16;
    logic        refclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_chan = '0;
    logic [15:0] cfg_num = '0;
    logic [15:0] cfg_den = '0;
    logic        cfg_err;
    logic [2:0]  ce_out;
    logic        locked;
    int n_checks = 0;
    int n_fail = 0;
    int cyc;
    int cnt[3], last[3], first[3], smin[3], smax[3];

    clkgen_frac #(
        .CHANNELS(3),
        .ACC_W(16),
        .LOCK_CYCLES(LOCK),
        .INIT_NUM({16'd4, 16'd3, 16'd1}),
        .INIT_DEN({16'd4, 16'd8, 16'd4})
    ) dut (
        .refclk(refclk),
        .rst_n(rst_n),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_chan(cfg_chan),
        .cfg_num(cfg_num),
        .cfg_den(cfg_den),
        .cfg_err(cfg_err),
        .ce_out(ce_out),
        .locked(locked)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        cyc = 0;
        for (int c = 0; c < 3; c++) begin
            cnt[c] = 0; last[c] = 0; first[c] = 0; smin[c] = 1000; smax[c] = 0;
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
        cyc++;
        for (int c = 0; c < 3; c++)
            if (ce_out[c]) begin
                if (last[c] > 0) begin
                    if (cyc - last[c] < smin[c]) smin[c] = cyc - last[c];
                    if (cyc - last[c] > smax[c]) smax[c] = cyc - last[c];
                end else first[c] = cyc;
                cnt[c]++;
                last[c] = cyc;
            end
    endtask

    task automatic relock(input string tag);
        int early = 0;
        clear_stats();
        for (int i = 1; i < LOCK; i++) begin
            tick();
            if (locked || cfg_ready || cfg_err) early++;
        end
        check({tag, "_early"}, 32'(early), 0);
        check({tag, "_ce_settle"}, 32'(cnt[0] + cnt[1] + cnt[2]), 0);
        tick();
        check({tag, "_locked"}, 32'(locked), 1);
        check({tag, "_ready"}, 32'(cfg_ready), 1);
        clear_stats();
    endtask

    task automatic bad_cfg(input string tag, input logic [1:0] ch, input logic [15:0] n, input logic [15:0] d);
        cfg_valid = 1'b1; cfg_chan = ch; cfg_num = n; cfg_den = d;
        tick();
        check({tag, "_err"}, 32'(cfg_err), 1);
        check({tag, "_locked"}, 32'(locked), 1);
        cfg_valid = 1'b0;
        tick();
        check({tag, "_err_end"}, 32'(cfg_err), 0);
    endtask

    initial begin
        clear_stats();
        repeat (3) tick();
        check("rst_locked", 32'(locked), 0);
        check("rst_ready", 32'(cfg_ready), 0);
        check("rst_err", 32'(cfg_err), 0);
        check("rst_ce", 32'(ce_out), 0);
        rst_n = 1'b1;
        relock("lock0");
        repeat (800) tick();
        check("r14_cnt", 32'(cnt[0]), 200);
        check("r14_smin", 32'(smin[0]), 4);
        check("r14_smax", 32'(smax[0]), 4);
        check("r14_first", 32'(first[0]), 4);
        check("r38_cnt", 32'(cnt[1]), 300);
        check("r38_smin", 32'(smin[1]), 2);
        check("r38_smax", 32'(smax[1]), 3);
        check("r38_first", 32'(first[1]), 3);
        check("r44_cnt", 32'(cnt[2]), 800);
        check("r44_first", 32'(first[2]), 1);
        clear_stats();
        bad_cfg("bad_num", 2'd0, 16'd5, 16'd4);
        bad_cfg("bad_den", 2'd1, 16'd0, 16'd0);
        bad_cfg("bad_chan", 2'd3, 16'd1, 16'd2);
        repeat (2) tick();
        check("bad_cnt0", 32'(cnt[0]), 2);
        check("bad_sp0", 32'(smin[0]), 4);
        check("bad_cnt1", 32'(cnt[1]), 3);
        check("bad_cnt2", 32'(cnt[2]), 8);
        cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_num = 16'd1; cfg_den = 16'd2;
        tick();
        check("cfg_locked", 32'(locked), 0);
        check("cfg_ready", 32'(cfg_ready), 0);
        check("cfg_ce", 32'(ce_out), 0);
        check("cfg_err", 32'(cfg_err), 0);
        cfg_chan = 2'd3;
        relock("lock1");
        tick();
        check("held_err", 32'(cfg_err), 1);
        check("held_locked", 32'(locked), 1);
        cfg_valid = 1'b0;
        tick();
        check("held_err_end", 32'(cfg_err), 0);
        repeat (14) tick();
        check("r12_cnt", 32'(cnt[0]), 8);
        check("r12_first", 32'(first[0]), 2);
        check("r12_smax", 32'(smax[0]), 2);
        check("r12_ch1_first", 32'(first[1]), 3);
        check("r12_ch1_cnt", 32'(cnt[1]), 6);
        check("r12_ch2_cnt", 32'(cnt[2]), 16);
        check("pre_rst_ce", 32'(ce_out), 7);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ce", 32'(ce_out), 0);
        check("arst_locked", 32'(locked), 0);
        check("arst_ready", 32'(cfg_ready), 0);
        @(posedge refclk);
        #1 rst_n = 1'b1;
        relock("lock2");
        repeat (16) tick();
        check("rev_cnt0", 32'(cnt[0]), 4);
        check("rev_first0", 32'(first[0]), 4);
        check("rev_cnt1", 32'(cnt[1]), 6);
        check("rev_cnt2", 32'(cnt[2]), 16);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
